// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB master port.
// Optional macro APB_ARB_LOCK_EN adds m_lock_i for locked ownership.
module apb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 8
) (
  input  logic                                   apb_pclk_i,
  input  logic                                   apb_preset_i,
  input  logic [NUM_MASTERS-1:0]                 m_psel_i,
  input  logic [NUM_MASTERS-1:0]                 m_penable_i,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0]  m_paddr_i,
  input  logic [NUM_MASTERS-1:0]                 m_pwrite_i,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  m_pwdata_i,
`ifdef APB_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]                 m_lock_i,
`endif
  output logic [APB_DATA_WIDTH-1:0]              m_prdata_o,
  output logic [NUM_MASTERS-1:0]                 m_pready_o,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   apb_psel_o,
  output logic                                   apb_penable_o,
  output logic                                   apb_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]              apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]              apb_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]              apb_prdata_i,
  input  logic                                   apb_pready_i
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] base;
  logic [IW-1:0] pick;
  logic [IW-1:0] sel_idx;
  logic          found;
  logic          sel_vld;
  logic          done;
  logic          unused_penable;

  // requester PENABLE is only informational here
  assign unused_penable = ^m_penable_i;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] v);
    return (v == IW'(N - 1)) ? '0 : v + IW'(1);
  endfunction

`ifdef APB_ARB_LOCK_EN
  logic lock_vld;
  logic lock_hit;

  assign lock_hit = lock_vld && m_psel_i[g_idx];
  assign base     = lock_vld ? nxt(g_idx) : rr_ptr;
  assign sel_vld  = lock_hit | found;
  assign sel_idx  = lock_hit ? g_idx : pick;
`else
  assign base     = rr_ptr;
  assign sel_vld  = found;
  assign sel_idx  = pick;
`endif

  assign done       = (state == ACCESS) && apb_pready_i;
  assign m_pready_o = done ? grant_o : '0;
  assign m_prdata_o = apb_prdata_i;

  // first active request at or above base, wrapping modulo N
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && m_psel_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // transfer FSM with registered downstream bus and grant
  always_ff @(posedge apb_pclk_i) begin
    if (apb_preset_i) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      g_idx         <= '0;
      grant_o       <= '0;
      apb_psel_o    <= 1'b0;
      apb_penable_o <= 1'b0;
      apb_pwrite_o  <= 1'b0;
      apb_paddr_o   <= '0;
      apb_pwdata_o  <= '0;
`ifdef APB_ARB_LOCK_EN
      lock_vld      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
`ifdef APB_ARB_LOCK_EN
          if (lock_vld && !lock_hit) begin
            lock_vld <= 1'b0;
            rr_ptr   <= nxt(g_idx);
          end
`endif
          if (sel_vld) begin
            g_idx        <= sel_idx;
            grant_o      <= N'(1) << sel_idx;
            apb_paddr_o  <= m_paddr_i[sel_idx*AW +: AW];
            apb_pwdata_o <= m_pwdata_i[sel_idx*DW +: DW];
            apb_pwrite_o <= m_pwrite_i[sel_idx];
            apb_psel_o   <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          apb_penable_o <= 1'b1;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (apb_pready_i) begin
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            grant_o       <= '0;
            state         <= IDLE;
`ifdef APB_ARB_LOCK_EN
            if (m_lock_i[g_idx]) begin
              lock_vld <= 1'b1;
            end else begin
              lock_vld <= 1'b0;
              rr_ptr   <= nxt(g_idx);
            end
`else
            rr_ptr <= nxt(g_idx);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB master port between up to NUM_MASTERS upstream APB requesters, for example the SPI bridge plug and a debug or DMA master.
- Round-robin arbitration at transfer granularity.
- Registers the granted request and drives APB SETUP/ACCESS phases downstream.
- Returns PRDATA/PREADY to the granted requester only. Sits between the requesters and the peripheral interconnect in the apb_pclk_i domain.

Parameters:
- NUM_MASTERS, 2, number of upstream requesters (2..8)
- APB_ADDR_WIDTH, 12, APB address width
- APB_DATA_WIDTH, 8, APB data width

Ports:
- apb_pclk_i  in  1  APB clock; the only clock.
- apb_preset_i  in  1  reset. Synchronous, active-high.
- m_psel_i  in  NUM_MASTERS  per-requester PSEL.
- m_penable_i  in  NUM_MASTERS  per-requester PENABLE (protocol tracking only).
- m_paddr_i  in  NUM_MASTERS*APB_ADDR_WIDTH  packed addresses; requester k occupies slice [k*AW +: AW].
- m_pwrite_i  in  NUM_MASTERS  per-requester PWRITE.
- m_pwdata_i  in  NUM_MASTERS*APB_DATA_WIDTH  packed write data.
- m_prdata_o  out  APB_DATA_WIDTH  read data, broadcast to all requesters.
- m_pready_o  out  NUM_MASTERS  per-requester PREADY.
- grant_o  out  NUM_MASTERS  one-hot current owner; zero when idle.
- apb_psel_o, apb_penable_o, apb_pwrite_o  out  1  downstream APB controls.
- apb_paddr_o  out  APB_ADDR_WIDTH  downstream address.
- apb_pwdata_o  out  APB_DATA_WIDTH  downstream write data.
- apb_prdata_i  in  APB_DATA_WIDTH  downstream read data.
- apb_pready_i  in  1  downstream ready.

Behaviour:
- Reset:
  - all outputs 0; FSM in IDLE; rr_ptr = 0, so requester 0 has highest priority.
  - Reset overrides every state, including mid-ACCESS. The aborted transfer is dropped and no m_pready_o is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req = m_psel_i. If req is nonzero, pick the first set bit starting at rr_ptr and searching upward modulo NUM_MASTERS.
  - Capture that requester's paddr, pwrite and pwdata into the output registers. Set grant_o one-hot, go to SETUP.
  - If req is zero, stay in IDLE with grant_o = 0.
- SETUP: apb_psel_o = 1, apb_penable_o = 0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - apb_psel_o = 1, apb_penable_o = 1. Hold until apb_pready_i = 1.
  - In the cycle apb_pready_i = 1: m_pready_o[g] = 1 combinationally (ACCESS & apb_pready_i), where g is the granted index.
  - On that edge: rr_ptr <= (g + 1) mod NUM_MASTERS; clear apb_psel_o, apb_penable_o and grant_o; return to IDLE.
- m_pready_o[k] = 0 for every k != g and in every other state.
- m_prdata_o = apb_prdata_i, combinational pass-through. It is valid only when the owner's m_pready_o is high.
- Downstream address, control and wdata stay stable from SETUP through ACCESS completion, even if the requester changes its inputs.
- Timing:
  - Latency from request seen in IDLE to apb_psel_o high is 1 cycle.
  - A transfer with zero wait states occupies 3 cycles: IDLE, SETUP, ACCESS.
  - Between consecutive transfers there is always exactly one IDLE cycle.
- Simultaneous requests: only one is granted per IDLE cycle. The others keep PSEL high and wait; no request is lost.
- A requester that drops m_psel_i before being granted is simply not considered. Once granted, its later input changes are ignored until completion.
- Wrap-around: after granting index NUM_MASTERS-1, rr_ptr becomes 0.
- Fairness: with N requesters continuously requesting, each is served once in every N transfers.

Optional Feature:
- Macro: APB_ARB_LOCK_EN.
- When defined:
  - Adds input m_lock_i [NUM_MASTERS].
  - If m_lock_i[g] = 1 on the completion edge, rr_ptr is left unchanged and the arbiter records g as locked owner.
  - In the next IDLE, if m_psel_i[g] = 1, g is granted regardless of the other requests.
  - The lock is released when m_lock_i[g] = 0 at completion, or when g is not requesting in IDLE. rr_ptr then advances to g+1 as normal.
  - Reset clears the lock.
- When not defined: the port is absent and arbitration is pure round-robin.

Test Plan:
- Single write: req0 with paddr=0x123, pwdata=0xA5, pwrite=1, pready tied 1.
  -> apb_psel_o high cycles 1-2, apb_penable_o high cycle 2, m_pready_o = 01 in cycle 2, downstream sees 0x123/0xA5.
- Read with wait states: req1 read of 0x040, pready delayed 3 cycles, prdata=0x5C.
  -> ACCESS lasts 4 cycles; m_pready_o = 10 only in the last one, with m_prdata_o = 0x5C.
- Contention, NUM_MASTERS=2: both request continuously for 4 transfers.
  -> grant order 0,1,0,1; one IDLE cycle between transfers.
- Wrap-around, NUM_MASTERS=3: requests on 2 and 0 only.
  -> grant order 2,0,2,0 after an initial grant of 0 from reset.
- Reset mid-ACCESS: assert apb_preset_i while in ACCESS with pready=0.
  -> next cycle all outputs 0, no m_pready_o pulse; a following req1 is granted before req0 because rr_ptr=0 and only req1 is present.
- APB_ARB_LOCK_EN: req0 with lock=1 for 3 transfers while req1 requests.
  -> grants 0,0,0, then req0 drops lock -> 1.
